// File: rtl/ysyx_pkg.sv
// Shared types and defaults for the integer register write-back path.
// Width macros fall back to RV32I-sized defaults when the build does not set them.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_REG_NUM
`define YSYX_REG_NUM 32
`endif

package ysyx_pkg;

  localparam int XLEN_DEF    = `YSYX_XLEN;
  localparam int REG_LEN_DEF = `YSYX_REG_LEN;
  localparam int REG_NUM_DEF = `YSYX_REG_NUM;
  localparam int CNT_W_DEF   = 2;

  typedef struct packed {
    logic                valid;
    logic [4:0]          rd;
    logic [XLEN_DEF-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/ysyx_wb_rr_arb2.sv
// Two-way round-robin grant for the write-back port (bit 0 = EXU, bit 1 = LSU).
// The last pointer only moves on a tie, so a lone requester never costs the other its turn.
module ysyx_wb_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!flush) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (!flush && (req == 2'b11)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/ysyx_reg_wb_arb.sv
// Write-back arbiter and RAW scoreboard in front of ysyx_reg's single write port.
// Optional forwarding of the in-flight write is enabled by YSYX_WB_BYPASS_EN.
module ysyx_reg_wb_arb
  import ysyx_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_LEN = REG_LEN_DEF,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            flush,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_wdata,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      s1addr,
  input  logic [4:0]      s2addr,
  output logic            s1_busy,
  output logic            s2_busy,
  output logic            s1_fwd_valid,
  output logic            s2_fwd_valid,
  output logic [XLEN-1:0] s1_fwd_data,
  output logic [XLEN-1:0] s2_fwd_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt [REG_NUM];
  wb_req_t            exu_req;
  wb_req_t            lsu_req;
  wb_req_t            win_req;
  logic [1:0]         gnt;
  logic               wb_fire;
  logic               issue_fire;
  logic [REG_LEN-1:0] issue_idx;
  logic [REG_LEN-1:0] wb_idx;
  logic [REG_NUM-1:0] inc_vec;
  logic [REG_NUM-1:0] dec_vec;

  assign exu_req = '{valid: exu_valid, rd: exu_rd, wdata: exu_wdata};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, wdata: lsu_wdata};

  ysyx_wb_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .req   ({lsu_valid, exu_valid}),
    .gnt   (gnt)
  );

  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign win_req   = gnt[1] ? lsu_req : exu_req;
  assign wb_fire   = (|gnt) && win_req.valid;

  assign issue_idx   = issue_rd[REG_LEN-1:0];
  assign wb_idx      = win_req.rd[REG_LEN-1:0];
  assign issue_ready = (issue_idx == '0) || (cnt[issue_idx] != CNT_MAX);
  assign issue_fire  = issue_valid && issue_ready && !flush;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire && (issue_idx != '0)) inc_vec[issue_idx] = 1'b1;
    if (wb_fire && (wb_idx != '0))       dec_vec[wb_idx]    = 1'b1;
  end

  // A decrement on an empty counter is a write-back that survived a flush; it saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (wb_fire) begin
      rf_wen   <= (win_req.rd != 5'd0);
      rf_waddr <= win_req.rd;
      rf_wdata <= win_req.wdata;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  logic [4:0] q_addr [2];
  logic       q_busy [2];
  logic       q_fwd  [2];

  assign q_addr[0] = s1addr;
  assign q_addr[1] = s2addr;

  for (genvar k = 0; k < 2; k++) begin : g_query
    logic q_nz;
    logic q_pend;
    logic q_infl;

    assign q_nz   = (q_addr[k] != 5'd0);
    assign q_pend = (cnt[q_addr[k][REG_LEN-1:0]] != '0);
    // The counter drops at acceptance, one cycle before the register file holds the value.
    assign q_infl = rf_wen && (rf_waddr == q_addr[k]);
`ifdef YSYX_WB_BYPASS_EN
    assign q_fwd[k]  = q_infl && !q_pend && q_nz;
    assign q_busy[k] = (q_pend || q_infl) && q_nz && !q_fwd[k];
`else
    assign q_fwd[k]  = 1'b0;
    assign q_busy[k] = (q_pend || q_infl) && q_nz;
`endif
  end

  assign s1_busy      = q_busy[0];
  assign s2_busy      = q_busy[1];
  assign s1_fwd_valid = q_fwd[0];
  assign s2_fwd_valid = q_fwd[1];
  assign s1_fwd_data  = q_fwd[0] ? rf_wdata : '0;
  assign s2_fwd_data  = q_fwd[1] ? rf_wdata : '0;

endmodule

// File: tb/tb_ysyx_reg_wb_arb.sv
// Bench for ysyx_reg_wb_arb: directed vector table, corner sequences, then random traffic
// checked every cycle against a counting model of the scoreboard and write port.
module tb_ysyx_reg_wb_arb;

`ifdef YSYX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, flush;
  logic [4:0]  issue_rd;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [31:0] exu_wdata, lsu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  s1addr, s2addr;
  logic        s1_busy, s2_busy, s1_fwd_valid, s2_fwd_valid;
  logic [31:0] s1_fwd_data, s2_fwd_data;

  ysyx_reg_wb_arb #(.XLEN(32), .REG_LEN(5), .REG_NUM(32), .CNT_W(2)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .flush(flush),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_wdata(exu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .s1addr(s1addr), .s2addr(s2addr),
    .s1_busy(s1_busy), .s2_busy(s2_busy),
    .s1_fwd_valid(s1_fwd_valid), .s2_fwd_valid(s2_fwd_valid),
    .s1_fwd_data(s1_fwd_data), .s2_fwd_data(s2_fwd_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: outstanding-write count per register, tie pointer, and the last accepted write.
  int          m_cnt [32];
  int          m_last;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          e_exu_acc, e_lsu_acc, e_iready;

  task automatic exp_q(input logic [4:0] a, output bit busy, output bit fwd);
    bit infl, pend;
    infl = m_wen && (m_waddr == a);
    pend = (m_cnt[a] != 0);
    fwd  = BYP && infl && !pend && (a != 0);
    busy = (pend || infl) && (a != 0) && !fwd;
  endtask

  task automatic sample();
    bit b1, f1, b2, f2;
    @(negedge clock);
    e_exu_acc = !flush && exu_valid && (!lsu_valid || m_last == 1);
    e_lsu_acc = !flush && lsu_valid && (!exu_valid || m_last == 0);
    e_iready  = (issue_rd == 0) || (m_cnt[issue_rd] < 3);
    exp_q(s1addr, b1, f1);
    exp_q(s2addr, b2, f2);
    chk("exu_ready", exu_ready, e_exu_acc);
    chk("lsu_ready", lsu_ready, e_lsu_acc);
    chk("issue_ready", issue_ready, e_iready);
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("s1_busy", s1_busy, b1);
    chk("s2_busy", s2_busy, b2);
    chk("s1_fwd_valid", s1_fwd_valid, f1);
    chk("s2_fwd_valid", s2_fwd_valid, f2);
    if (f1) chk("s1_fwd_data", s1_fwd_data, m_wdata);
    if (f2) chk("s2_fwd_data", s2_fwd_data, m_wdata);
  endtask

  task automatic advance();
    logic [4:0]  wrd;
    logic [31:0] wdat;
    @(posedge clock);
    wrd  = e_lsu_acc ? lsu_rd : exu_rd;
    wdat = e_lsu_acc ? lsu_wdata : exu_wdata;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      if (issue_valid && e_iready && issue_rd != 0) m_cnt[issue_rd] += 1;
      if ((e_exu_acc || e_lsu_acc) && wrd != 0 && m_cnt[wrd] > 0) m_cnt[wrd] -= 1;
      if (exu_valid && lsu_valid) m_last = e_exu_acc ? 0 : 1;
    end
    m_wen = (e_exu_acc || e_lsu_acc) && (wrd != 0);
    if (e_exu_acc || e_lsu_acc) begin
      m_waddr = wrd;
      m_wdata = wdat;
    end
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; flush = 0;
    exu_valid = 0; exu_rd = 0; exu_wdata = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
    s1addr = 0; s2addr = 0;
  endtask

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        ev;  logic [4:0] erd; logic [31:0] ed;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic [4:0]  s1;  logic [4:0] s2;
    logic        er;  logic lr; logic wen; logic [4:0] waddr; logic [31:0] wdata;
    logic        b1;  logic b2;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Single EXU write to x5, then a three-cycle EXU/LSU tie on x1/x2.
    tbl[0] = '{1, 5, 0, 0, 0,            0, 0, 0,  5, 0, 0, 0, 0, 0, 0,            0,    0};
    tbl[1] = '{0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,  5, 0, 1, 0, 0, 0, 0,            1,    0};
    tbl[2] = '{0, 0, 0, 0, 0,            0, 0, 0,  5, 0, 0, 0, 1, 5, 32'hDEADBEEF, !BYP, 0};
    tbl[3] = '{0, 0, 0, 0, 0,            0, 0, 0,  5, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0,    0};
    tbl[4] = '{0, 0, 1, 1, 32'h11,       1, 2, 32'h22, 1, 2, 1, 0, 0, 5, 32'hDEADBEEF, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 32'h33,       1, 2, 32'h22, 1, 2, 0, 1, 1, 1, 32'h11, !BYP, 0};
    tbl[6] = '{0, 0, 1, 1, 32'h33,       1, 2, 32'h44, 1, 2, 1, 0, 1, 2, 32'h22, 0, !BYP};
    tbl[7] = '{0, 0, 0, 0, 0,            0, 0, 0,  1, 2, 0, 0, 1, 1, 32'h33,       !BYP, 0};
    tbl[8] = '{0, 0, 0, 0, 0,            0, 0, 0,  1, 2, 0, 0, 0, 1, 32'h33,       0,    0};

    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_last = 1; m_wen = 0; m_waddr = 0; m_wdata = 0;
    e_exu_acc = 0; e_lsu_acc = 0; e_iready = 1;

    idle();
    reset = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;

    s1addr = 5;
    sample();
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_s1_busy", s1_busy, 0);
    chk("rst_s1_fwd", s1_fwd_valid, 0);
    advance();

    for (int i = 0; i < 9; i++) begin
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird; flush = 0;
      exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_wdata = tbl[i].ed;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_wdata = tbl[i].ld;
      s1addr = tbl[i].s1; s2addr = tbl[i].s2;
      sample();
      chk($sformatf("vec%0d_exu_ready", i), exu_ready, tbl[i].er);
      chk($sformatf("vec%0d_lsu_ready", i), lsu_ready, tbl[i].lr);
      chk($sformatf("vec%0d_rf_wen", i), rf_wen, tbl[i].wen);
      chk($sformatf("vec%0d_rf_waddr", i), rf_waddr, tbl[i].waddr);
      chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, tbl[i].wdata);
      chk($sformatf("vec%0d_s1_busy", i), s1_busy, tbl[i].b1);
      chk($sformatf("vec%0d_s2_busy", i), s2_busy, tbl[i].b2);
      advance();
    end

    // Saturation of x7 at three outstanding writes.
    idle();
    issue_valid = 1; issue_rd = 7;
    repeat (3) begin sample(); advance(); end
    sample();
    chk("sat_issue_ready", issue_ready, 0);
    advance();
    issue_valid = 0; exu_valid = 1; exu_rd = 7; exu_wdata = 32'h77; s1addr = 7;
    sample();
    chk("sat_busy", s1_busy, 1);
    chk("sat_ready_before_wb", issue_ready, 0);
    advance();
    exu_valid = 0;
    sample();
    chk("sat_release", issue_ready, 1);
    advance();
    exu_valid = 1;
    repeat (2) begin sample(); advance(); end
    idle();
    repeat (2) begin sample(); advance(); end

    // Issue and write-back of x3 in the same cycle.
    issue_valid = 1; issue_rd = 3;
    sample(); advance();
    exu_valid = 1; exu_rd = 3; exu_wdata = 32'h5; s1addr = 3;
    sample(); advance();
    issue_valid = 0; exu_valid = 0;
    sample();
    chk("simul_busy", s1_busy, 1);
    advance();
    exu_valid = 1;
    sample(); advance();
    idle();
    repeat (2) begin sample(); advance(); end

    // Flush with x4 and x9 pending while EXU holds a write to x4.
    issue_valid = 1; issue_rd = 4;
    sample(); advance();
    issue_rd = 9;
    sample(); advance();
    issue_valid = 0; flush = 1;
    exu_valid = 1; exu_rd = 4; exu_wdata = 32'h44; s1addr = 4; s2addr = 9;
    sample();
    chk("flush_exu_ready", exu_ready, 0);
    advance();
    flush = 0;
    sample();
    chk("flush_s1_busy", s1_busy, 0);
    chk("flush_s2_busy", s2_busy, 0);
    chk("flush_exu_accept", exu_ready, 1);
    advance();
    exu_valid = 0;
    sample();
    chk("flush_late_wen", rf_wen, 1);
    advance();
    sample();
    chk("flush_cnt_zero", s1_busy, 0);
    advance();

    // LSU write of x10 observed on source 2.
    idle();
    issue_valid = 1; issue_rd = 10;
    sample(); advance();
    issue_valid = 0; lsu_valid = 1; lsu_rd = 10; lsu_wdata = 32'h1234; s2addr = 10;
    sample();
    chk("byp_pre_busy", s2_busy, 1);
    advance();
    lsu_valid = 0;
    sample();
    chk("byp_s2_busy", s2_busy, !BYP);
    chk("byp_s2_fwd_valid", s2_fwd_valid, BYP);
    chk("byp_s2_fwd_data", s2_fwd_data, BYP ? 32'h1234 : 32'h0);
    advance();

    // Random traffic; pending requests hold rd/data until accepted.
    idle();
    for (int c = 0; c < 3000; c++) begin
      if (!exu_valid || e_exu_acc) begin
        exu_valid = ($urandom % 3) != 0; exu_rd = 5'($urandom % 8); exu_wdata = $urandom;
      end
      if (!lsu_valid || e_lsu_acc) begin
        lsu_valid = ($urandom % 3) != 0; lsu_rd = 5'($urandom % 8); lsu_wdata = $urandom;
      end
      issue_valid = $urandom % 2;
      issue_rd    = 5'($urandom % 8);
      s1addr      = 5'($urandom % 8);
      s2addr      = 5'($urandom % 8);
      flush       = ($urandom % 32) == 0;
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_reg_wb_arb.md
# ysyx_reg_wb_arb

Write-back arbiter and scoreboard for the integer register file. It shares the register file's single write port between two write-back requesters, the EXU (requester 0) and the LSU (requester 1), using round-robin arbitration with a registered write port. It also tracks outstanding destination writes so that decode can stall on RAW hazards. It sits between the EXU/LSU result paths and `ysyx_reg`, and drives that block's `write_en`/`waddr`/`wdata`.

## Interface
Parameters:
- XLEN, `YSYX_XLEN: data width.
- REG_LEN, `YSYX_REG_LEN: index bits actually used from 5-bit register addresses.
- REG_NUM, `YSYX_REG_NUM: number of architectural registers tracked.
- CNT_W, 2: width of each per-register pending counter. Maximum outstanding writes per register is 2^CNT_W-1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode issues an instruction that writes `issue_rd`.
- issue_rd  in  5  destination register of the issued instruction.
- issue_ready  out  1  low when `issue_rd`'s counter is saturated.
- flush  in  1  pipeline flush; clears the scoreboard.
- exu_valid / exu_ready  in / out  1  EXU write-back handshake.
- exu_rd, exu_wdata  in  5, XLEN  EXU destination and result.
- lsu_valid / lsu_ready  in / out  1  LSU write-back handshake.
- lsu_rd, lsu_wdata  in  5, XLEN  LSU destination and result.
- rf_wen, rf_waddr, rf_wdata  out  1, 5, XLEN  registered write port to the register file.
- s1addr, s2addr  in  5  decode source-register queries.
- s1_busy, s2_busy  out  1  the source register has an unwritten producer.
- s1_fwd_valid, s2_fwd_valid  out  1  forwarded value is valid.
- s1_fwd_data, s2_fwd_data  out  XLEN  forwarded value.

## Operation
- **Handshake.** A transfer occurs when valid && ready in the same cycle. `valid`, `rd` and `wdata` stay stable until accepted. At most one requester is accepted per cycle.
- **Arbitration.** Round-robin using a 1-bit `last` pointer.
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not `last` wins, and `last` updates to the winner.
  - While `flush` is high, both ready outputs are 0.
- **Ready generation.** `exu_ready` and `lsu_ready` are combinational from the valids and `last`. They never depend on downstream state, because the write port is always free.
- **Write port.** An accepted transfer in cycle N produces, in cycle N+1:
  - `rf_wen` = (rd != 0)
  - `rf_waddr` = rd
  - `rf_wdata` = wdata
  
  With no transfer in N, `rf_wen` = 0 in N+1 and the address/data registers hold. An output already registered when `flush` rises still commits.
- **Scoreboard.** One CNT_W counter per register, indexed by rd[REG_LEN-1:0]. Register 0 is never tracked.
  - `issue_valid && issue_ready` increments `cnt[issue_rd]`.
  - An accepted write-back decrements `cnt[rd]`.
  - Increment and decrement of the same register in the same cycle leave the counter unchanged.
  - `flush` zeroes all counters. On the flush cycle, flush wins over a simultaneous issue (which is dropped) and over a simultaneous decrement.
  - A decrement of a counter already at 0 (a write after flush) saturates at 0.
- **Busy.** `sX_busy` = (`cnt[sX] != 0` || (`rf_wen` && `rf_waddr == sX`)) && `sX != 0`. The second term covers the cycle in which the counter has already dropped but the register file has not yet been written.

## Timing
- **Reset values.** All counters 0, `last` = 1 (the EXU wins the first tie), `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0. Every status output therefore resets to 0 except `issue_ready`, which resets to 1.
- **Latency.** Handshake to `rf_wen` is 1 cycle. The register file updates at the end of that cycle, so a read of the register returns the new value 2 cycles after the handshake.
- **Issue visibility.** An issue in cycle N makes the register busy from cycle N+1.
- **Combinational outputs.** Busy, forward and ready outputs are combinational from registered state and the current inputs.

## Configuration
- `YSYX_WB_BYPASS_EN` **defined:**
  - When `rf_wen && rf_waddr == sX && cnt[sX] == 0 && sX != 0`, then `sX_fwd_valid` = 1, `sX_fwd_data` = `rf_wdata`, and `sX_busy` = 0.
  - This removes one stall cycle per RAW dependency.
- `YSYX_WB_BYPASS_EN` **undefined:** the forward outputs are tied to 0 and busy follows the Operation rule above.

## Structure
- Shared `ysyx_pkg` holds the CNT_W default and a `wb_req_t` struct {valid, rd, wdata}.
- Sub-module `ysyx_wb_rr_arb2` is the 2-way round-robin grant with its `last` register. The counters, output register and query logic stay in the top module.

## Test plan
- **Single EXU write.** After reset, issue rd=5; next cycle EXU writes rd=5, data 0xDEADBEEF. Required: `s1_busy`(s1addr=5) = 1 until `rf_wen` clears; `rf_wen`/`rf_waddr`=5/`rf_wdata`=0xDEADBEEF exactly 1 cycle after the handshake.
- **Round-robin tie.** EXU and LSU both valid for 3 cycles with rd=1 and rd=2. Required grants: EXU, LSU, EXU; the non-granted ready is 0 in each cycle.
- **Counter saturation.** Issue rd=7 three times. Required: `issue_ready` = 0 for rd=7; the counter stays at 3; after one write-back, `issue_ready` returns to 1.
- **Simultaneous issue and write-back.** Issue rd=3 in the same cycle as an accepted write-back to rd=3 with count 1. Required: count stays 1 and `s1_busy`(3) remains 1.
- **Flush.** Flush with counts on rd=4 and rd=9 while EXU is valid. Required: EXU not accepted that cycle; all busy outputs 0 afterwards; a later write-back to rd=4 leaves the counter at 0.
- **Bypass.** With `YSYX_WB_BYPASS_EN`, LSU writes rd=10, data 0x1234, with s2addr=10. Required: `s2_fwd_valid` = 1, `s2_fwd_data` = 0x1234 and `s2_busy` = 0 in the `rf_wen` cycle. Without the macro: `s2_busy` = 1 in that cycle.
